// File: rtl/song_rd_if.sv
`default_nettype none
// ============================================================================
//  Module   : song_rd_if
//  Purpose  : Random-access read port of the song-data buffer. The playback
//             side is the master (issues reads), the recorder is the slave.
//  Revision : 1.0 - initial release
// ============================================================================
interface song_rd_if #(
  parameter int ADDR_BITS = 6,
  parameter int DATA_BITS = 13
);
  logic                 rd_en;
  logic [ADDR_BITS-1:0] rd_addr;
  logic [DATA_BITS-1:0] rd_data;
  logic                 rd_valid;

  modport master (output rd_en, output rd_addr, input  rd_data, input  rd_valid);
  modport slave  (input  rd_en, input  rd_addr, output rd_data, output rd_valid);
endinterface
`default_nettype wire

// File: rtl/song_recorder.sv
`default_nettype none
// ============================================================================
//  Module   : song_recorder
//  Purpose  : Records live keyboard input (one-hot note + octave) as a list of
//             (octave, note, duration) entries, with a registered read port so
//             playback can stream the captured song like a stored one.
//  Revision : 1.0 - initial release
// ============================================================================
module song_recorder #(
  parameter int DEPTH     = 64,
  parameter int ADDR_BITS = 6,
  parameter int DUR_BITS  = 8,
  parameter int TICK_DIV  = 10
) (
  input  wire logic       clk,
  input  wire logic       reset,
  input  wire logic       tick,
  input  wire logic       start,
  input  wire logic       stop,
  input  wire logic [6:0] note_key,
  input  wire logic [1:0] octave,
  song_rd_if.slave        rd,
  output logic [ADDR_BITS:0] count,
  output logic            rec_active,
  output logic            done,
  output logic            full
);

  localparam int c_DATA_BITS = 5 + DUR_BITS;
  localparam int c_SUB_BITS  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_SUB_BITS-1:0] c_SUB_LAST = c_SUB_BITS'(TICK_DIV - 1);
  localparam logic [DUR_BITS-1:0]   c_DUR_MAX  = '1;
  localparam logic [ADDR_BITS:0]    c_LAST_CNT = (ADDR_BITS+1)'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WAIT_FIRST = 2'd1,
    S_RECORD     = 2'd2,
    S_DONE       = 2'd3
  } state_t;

  state_t                   r_state, w_state_nxt;
  logic [ADDR_BITS:0]       r_count, w_count_nxt;
  logic                     r_full, w_full_nxt;
  logic [4:0]               r_pend, w_pend_nxt;
  logic [DUR_BITS-1:0]      r_dur, w_dur_nxt;
  logic [c_SUB_BITS-1:0]    r_sub, w_sub_nxt;
  logic                     w_wr_en;
  logic [2:0]               w_note_idx;
  logic [4:0]               w_sym;
  logic [c_DATA_BITS-1:0]   r_mem [DEPTH];
  logic [c_DATA_BITS-1:0]   r_rd_data;
  logic                     r_rd_valid;

  // Encode the key bank: lowest pressed key wins, no key means rest (0).
  always_comb begin
    w_note_idx = 3'd0;
    for (int i = 6; i >= 0; i--) begin
      if (note_key[i]) w_note_idx = 3'(i + 1);
    end
  end

  assign w_sym = {octave, w_note_idx};

  // Next-state, duration timing and commit decision.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_full_nxt  = r_full;
    w_pend_nxt  = r_pend;
    w_dur_nxt   = r_dur;
    w_sub_nxt   = r_sub;
    w_wr_en     = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nxt = S_WAIT_FIRST;
          w_count_nxt = '0;
          w_full_nxt  = 1'b0;
        end
      end
      S_WAIT_FIRST: begin
        if (stop) begin
          w_state_nxt = S_DONE;
        end else if (note_key != 7'd0) begin
          w_state_nxt = S_RECORD;
          w_pend_nxt  = w_sym;
          w_dur_nxt   = '0;
          w_sub_nxt   = '0;
        end
      end
      S_RECORD: begin
        if (stop) begin
          // A trailing rest carries no musical content, so it is dropped.
          w_wr_en     = (r_dur != '0) && (r_pend[2:0] != 3'd0);
          w_state_nxt = S_DONE;
        end else if (w_sym != r_pend) begin
          // Sub-unit symbols are key bounce, not notes.
          w_wr_en    = (r_dur != '0);
          w_pend_nxt = w_sym;
          w_dur_nxt  = '0;
          w_sub_nxt  = '0;
        end else if (tick) begin
          if (r_sub == c_SUB_LAST) begin
            w_sub_nxt = '0;
            if (r_dur == c_DUR_MAX) begin
              // Long note: flush a max-length entry and keep counting.
              w_wr_en   = 1'b1;
              w_dur_nxt = DUR_BITS'(1);
            end else begin
              w_dur_nxt = r_dur + 1'b1;
            end
          end else begin
            w_sub_nxt = r_sub + 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_wr_en) begin
      w_count_nxt = r_count + 1'b1;
      if (r_count == c_LAST_CNT) begin
        w_full_nxt  = 1'b1;
        w_state_nxt = S_DONE;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_full  <= 1'b0;
      r_pend  <= '0;
      r_dur   <= '0;
      r_sub   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_full  <= w_full_nxt;
      r_pend  <= w_pend_nxt;
      r_dur   <= w_dur_nxt;
      r_sub   <= w_sub_nxt;
    end
  end

  // Entry storage; pending symbol and duration are captured before update.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_count[ADDR_BITS-1:0]] <= {r_pend, r_dur};
  end

  // Registered read port; reads beyond the committed count return zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else if (rd.rd_en) begin
      if ({1'b0, rd.rd_addr} < r_count) begin
        r_rd_data  <= r_mem[rd.rd_addr];
        r_rd_valid <= 1'b1;
      end else begin
        r_rd_data  <= '0;
        r_rd_valid <= 1'b0;
      end
    end else begin
      r_rd_valid <= 1'b0;
    end
  end

  assign rd.rd_data  = r_rd_data;
  assign rd.rd_valid = r_rd_valid;
  assign count       = r_count;
  assign full        = r_full;
  assign rec_active  = (r_state == S_WAIT_FIRST) || (r_state == S_RECORD);
  assign done        = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_song_recorder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_song_recorder
//  Purpose  : Directed self-checking bench for song_recorder.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_song_recorder;

  localparam int c_ADDR_BITS = 6;
  localparam int c_DATA_BITS = 13;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [6:0] note_key = 7'd0;
  logic [1:0] octave = 2'd0;
  logic [c_ADDR_BITS:0] count;
  logic       rec_active, done, full;

  int n_checks = 0;
  int n_pass   = 0;

  logic [c_DATA_BITS-1:0] r_data;
  logic                   r_valid;

  song_rd_if #(.ADDR_BITS(c_ADDR_BITS), .DATA_BITS(c_DATA_BITS)) rd_if ();

  song_recorder dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .start      (start),
    .stop       (stop),
    .note_key   (note_key),
    .octave     (octave),
    .rd         (rd_if),
    .count      (count),
    .rec_active (rec_active),
    .done       (done),
    .full       (full)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time exhausted, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] ent(input int o, input int n, input int d);
    return 32'({2'(o), 3'(n), 8'(d)});
  endfunction

  // One ms = one tick cycle followed by one quiet cycle.
  task automatic ms(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); tick = 1'b1;
      @(negedge clk); tick = 1'b0;
    end
  endtask

  task automatic pulse(input logic s_start, input logic s_stop);
    @(negedge clk); start = s_start; stop = s_stop;
    @(negedge clk); start = 1'b0; stop = 1'b0;
  endtask

  task automatic rd(input int addr);
    @(negedge clk); rd_if.rd_en = 1'b1; rd_if.rd_addr = 6'(addr);
    @(negedge clk); rd_if.rd_en = 1'b0;
    r_data = rd_if.rd_data; r_valid = rd_if.rd_valid;
  endtask

  initial begin
    rd_if.rd_en = 1'b0; rd_if.rd_addr = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state and read of an empty buffer.
    rd(0);
    check("rst_rd_valid", 32'(r_valid), 0);
    check("rst_rd_data", 32'(r_data), 0);
    check("rst_count", 32'(count), 0);
    check("rst_done", 32'(done), 0);
    check("rst_active", 32'(rec_active), 0);
    check("rst_full", 32'(full), 0);

    // Two notes after leading silence.
    pulse(1'b1, 1'b0);
    check("t1_active", 32'(rec_active), 1);
    ms(50);
    note_key = 7'b0000001; octave = 2'd1;
    ms(250);
    note_key = 7'b0000100;
    ms(120);
    pulse(1'b0, 1'b1);
    check("t1_count", 32'(count), 2);
    check("t1_done", 32'(done), 1);
    check("t1_active_off", 32'(rec_active), 0);
    rd(0); check("t1_e0", 32'(r_data), ent(1, 1, 25)); check("t1_e0_v", 32'(r_valid), 1);
    rd(1); check("t1_e1", 32'(r_data), ent(1, 3, 12));
    rd(2); check("t1_oob_data", 32'(r_data), 0); check("t1_oob_v", 32'(r_valid), 0);
    rd(1);
    @(negedge clk);
    check("hold_valid", 32'(rd_if.rd_valid), 0);
    check("hold_data", 32'(rd_if.rd_data), ent(1, 3, 12));

    // Short glitch between two notes is discarded.
    note_key = 7'd0; octave = 2'd0;
    pulse(1'b1, 1'b0);
    note_key = 7'b0000001; ms(100);
    note_key = 7'b0000010; ms(5);
    note_key = 7'b0000001; ms(100);
    pulse(1'b0, 1'b1);
    check("gl_count", 32'(count), 2);
    rd(0); check("gl_e0", 32'(r_data), ent(0, 1, 10));
    rd(1); check("gl_e1", 32'(r_data), ent(0, 1, 10));

    // 300-unit note splits into 255 + 45.
    note_key = 7'd0;
    pulse(1'b1, 1'b0);
    note_key = 7'b1000000; octave = 2'd2;
    ms(3000);
    pulse(1'b0, 1'b1);
    check("sat_count", 32'(count), 2);
    rd(0); check("sat_e0", 32'(r_data), ent(2, 7, 255));
    rd(1); check("sat_e1", 32'(r_data), ent(2, 7, 45));

    // Trailing rest is dropped on stop.
    note_key = 7'd0; octave = 2'd0;
    pulse(1'b1, 1'b0);
    note_key = 7'b0000001; ms(10);
    note_key = 7'd0; ms(30);
    pulse(1'b0, 1'b1);
    check("rest_count", 32'(count), 1);
    rd(0); check("rest_e0", 32'(r_data), ent(0, 1, 1));

    // Fill the buffer with 64 alternating 20 ms notes.
    pulse(1'b1, 1'b0);
    note_key = 7'b0000001; ms(20);
    for (int i = 0; i < 64; i++) begin
      note_key = (i % 2 == 0) ? 7'b0000010 : 7'b0000001;
      ms(20);
    end
    check("full_full", 32'(full), 1);
    check("full_done", 32'(done), 1);
    check("full_count", 32'(count), 64);
    note_key = 7'b0000100; ms(2);
    check("full_hold", 32'(count), 64);
    rd(63); check("full_e63", 32'(r_data), ent(0, 2, 2)); check("full_e63_v", 32'(r_valid), 1);
    rd(0);  check("full_e0", 32'(r_data), ent(0, 1, 2));

    // Reset in the middle of a recording.
    note_key = 7'd0;
    pulse(1'b1, 1'b0);
    check("mid_full_clr", 32'(full), 0);
    note_key = 7'b0000001; ms(20);
    note_key = 7'b0000010; ms(20);
    note_key = 7'b0000001; ms(20);
    note_key = 7'b0000010; ms(20);
    check("mid_count", 32'(count), 3);
    check("mid_active", 32'(rec_active), 1);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    check("mid_rst_count", 32'(count), 0);
    check("mid_rst_active", 32'(rec_active), 0);
    check("mid_rst_done", 32'(done), 0);
    rd(0); check("mid_rst_rdv", 32'(r_valid), 0); check("mid_rst_rdd", 32'(r_data), 0);

    // Simultaneous start/stop priority in each state.
    note_key = 7'd0;
    pulse(1'b0, 1'b1);
    check("idle_stop_ign", 32'(rec_active | done), 0);
    pulse(1'b1, 1'b1);
    check("idle_both", 32'(rec_active), 1);
    pulse(1'b1, 1'b1);
    check("wait_both_done", 32'(done), 1);
    check("wait_both_cnt", 32'(count), 0);
    pulse(1'b1, 1'b1);
    check("done_both", 32'(rec_active), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
